ssd_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a common-anode multi-digit seven-segment display. It accepts a packed hex value over a valid/ready handshake and double-buffers it so the display never tears mid-frame. It cycles through the digits one at a time, presenting each digit's nibble, blank flag and decimal point to the downstream hex-to-segment decoder while driving the matching active-low digit select. It also performs leading-zero blanking.

---
 rtl/ssd_scan_ctrl.sv | 153 +++++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_ctrl.sv
// Scan controller for a common-anode multi-digit seven-segment display.
// A packed hex value is accepted over valid/ready into a pending buffer and
// promoted to the active buffer only at a frame boundary, so a frame never
// mixes two values. Digits are scanned one per dwell with active-low selects,
// a guard cycle at the start of each dwell, and optional leading-zero blanking.
module ssd_scan_ctrl #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 1000,
  parameter bit          LZ_BLANK = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_value,
  input  logic [DIGITS-1:0]     in_dp,
  output logic [3:0]            nibble,
  output logic                  blank,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_tick
);

  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PW = $clog2(PRESCALE);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [4*DIGITS-1:0] pend_val;
  logic [DIGITS-1:0]   pend_dp;
  logic                pend_full;
  logic [4*DIGITS-1:0] act_val;
  logic [DIGITS-1:0]   act_dp;
  logic [IW-1:0]       idx;
  logic [PW-1:0]       pre;

  logic                accept;
  logic                at_last_pre;
  logic                boundary;
  logic [DIGITS-1:0]   blank_mask;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic [DIGITS-1:0]   sel_n;

  assign in_ready    = !pend_full;
  assign accept      = in_valid && !pend_full;
  assign at_last_pre = (pre == PRE_LAST);
  assign boundary    = enable && at_last_pre && (idx == IDX_LAST);

  // Pending buffer: filled by the handshake, drained at a frame boundary.
  // Capture needs it empty and transfer needs it full, so the two never
  // coincide; a capture on a boundary edge waits for the next boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_val  <= '0;
      pend_dp   <= '0;
      pend_full <= 1'b0;
    end else if (accept) begin
      pend_val  <= in_value;
      pend_dp   <= in_dp;
      pend_full <= 1'b1;
    end else if (boundary && pend_full) begin
      pend_full <= 1'b0;
    end
  end

  // Active buffer: the value being displayed, swapped only between frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_val <= '0;
      act_dp  <= '0;
    end else if (boundary && pend_full) begin
      act_val <= pend_val;
      act_dp  <= pend_dp;
    end
  end

  // Dwell prescaler and digit index; both freeze while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
    end else if (enable) begin
      if (at_last_pre) begin
        pre <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

  // Leading-zero mask: walk from the most significant digit down, keeping a
  // running "everything so far is zero with no dp" flag. Digit 0 never blanks.
  always_comb begin
    logic run;
    run        = 1'b1;
    blank_mask = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      int unsigned i;
      i   = DIGITS - 1 - k;
      run = run && (act_val[4*i +: 4] == 4'h0) && !act_dp[i];
      if (LZ_BLANK && (i != 0))
        blank_mask[i] = run;
    end
  end

  // Select the current digit's nibble, dp and blank flag, and build the
  // active-low select with the guard cycle at the start of each dwell.
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_nib   = act_val[4*k +: 4];
        cur_dp    = act_dp[k];
        cur_blank = blank_mask[k];
      end
    end
    sel_n = '1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if ((idx == IW'(k)) && !cur_blank && (pre != '0))
        sel_n[k] = 1'b0;
    end
  end

  // Registered decoder-facing outputs, one cycle behind the scan state.
  always_ff @(posedge clk) begin
    if (rst) begin
      nibble     <= 4'h0;
      blank      <= 1'b1;
      dp         <= 1'b0;
      digit_sel  <= '1;
      frame_tick <= 1'b0;
    end else if (!enable) begin
      nibble     <= 4'h0;
      blank      <= 1'b1;
      dp         <= 1'b0;
      digit_sel  <= '1;
      frame_tick <= 1'b0;
    end else begin
      nibble     <= cur_blank ? 4'h0 : cur_nib;
      blank      <= cur_blank;
      dp         <= cur_blank ? 1'b0 : cur_dp;
      digit_sel  <= sel_n;
      frame_tick <= boundary;
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Self-checking bench for ssd_scan_ctrl (4 digits, 4-cycle dwell, LZ blanking).
// A table of display values with hand-derived blank masks is loaded through
// the handshake; each accepted value is queued with its capture edge and
// popped into the expected display at the frame boundary that promotes it.
module tb_ssd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_value;
  logic [3:0]  in_dp;
  logic [3:0]  nibble;
  logic        blank;
  logic        dp;
  logic [3:0]  digit_sel;
  logic        frame_tick;

  always #5 clk = ~clk;

  ssd_scan_ctrl #(
    .DIGITS   (4),
    .PRESCALE (4),
    .LZ_BLANK (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_value   (in_value),
    .in_dp      (in_dp),
    .nibble     (nibble),
    .blank      (blank),
    .dp         (dp),
    .digit_sel  (digit_sel),
    .frame_tick (frame_tick)
  );

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dpv;
    logic [3:0]  bmask;   // expected blanked digits (bit i = digit i)
  } entry_t;

  typedef struct {
    entry_t e;
    int     cap;          // edge number at which the DUT captured it
  } sb_t;

  entry_t tbl [8];
  entry_t zero_e;
  entry_t cur;
  sb_t    q [$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ph     = 0;
  bit armed  = 1'b0;
  bit en_e   = 1'b0;
  bit rst_e  = 1'b0;

  int          m_d;
  int          m_p;
  logic        m_bl;
  logic [15:0] m_v;
  logic [3:0]  m_nib;
  logic        m_dp;
  logic [3:0]  m_sel;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 60)
        $display("FAIL %s: got %h expected %h (cycle %0d, phase %0d)", name, got, exp, cyc, ph);
    end
  endtask

  // Edge bookkeeping: what the DUT saw at each rising edge.
  always @(posedge clk) begin
    cyc++;
    en_e  = enable;
    rst_e = rst;
    if (rst) armed = 1'b1;
  end

  // Output monitor: outputs after an edge reflect the state before it.
  always @(negedge clk) begin
    if (armed) begin
      if (rst_e) begin
        chk("rst_nibble", nibble, 16'h0);
        chk("rst_blank", blank, 16'h1);
        chk("rst_dp", dp, 16'h0);
        chk("rst_digit_sel", digit_sel, 16'hF);
        chk("rst_frame_tick", frame_tick, 16'h0);
        chk("rst_in_ready", in_ready, 16'h1);
        ph  = 0;
        cur = zero_e;
        q.delete();
      end else if (!en_e) begin
        chk("dis_blank", blank, 16'h1);
        chk("dis_dp", dp, 16'h0);
        chk("dis_digit_sel", digit_sel, 16'hF);
        chk("dis_frame_tick", frame_tick, 16'h0);
        chk("dis_in_ready", in_ready, 16'(q.size() == 0));
      end else begin
        m_d   = ph / 4;
        m_p   = ph % 4;
        m_bl  = cur.bmask[m_d];
        m_v   = cur.value >> (4 * m_d);
        m_nib = m_bl ? 4'h0 : m_v[3:0];
        m_dp  = m_bl ? 1'b0 : cur.dpv[m_d];
        m_sel = (m_bl || m_p == 0) ? 4'hF : ~(4'b0001 << m_d);
        chk("nibble", nibble, 16'(m_nib));
        chk("blank", blank, 16'(m_bl));
        chk("dp", dp, 16'(m_dp));
        chk("digit_sel", digit_sel, 16'(m_sel));
        chk("frame_tick", frame_tick, 16'(ph == 15));
        if (ph == 15 && q.size() > 0 && q[0].cap < cyc) begin
          cur = q[0].e;
          q.pop_front();
        end
        ph = (ph + 1) % 16;
        chk("in_ready", in_ready, 16'(q.size() == 0));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic send(input entry_t e);
    int n;
    n        = 0;
    in_value = e.value;
    in_dp    = e.dpv;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    chk("handshake_accept", in_ready, 16'h1);
    if (in_ready) q.push_back('{e: e, cap: cyc + 1});
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_ticks(input int n);
    int seen;
    int cnt;
    seen = 0;
    cnt  = 0;
    while (seen < n && cnt < 40 * n) begin
      step();
      if (frame_tick) seen++;
      cnt++;
    end
    chk("frame_tick_count", 16'(seen), 16'(n));
  endtask

  task automatic wait_ph(input int n);
    int cnt;
    cnt = 0;
    while (ph != n && cnt < 100) begin
      step();
      cnt++;
    end
    chk("wait_phase", 16'(ph), 16'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    enable   = 1'b1;
    in_valid = 1'b1;
    in_value = 16'h1234;
    in_dp    = 4'h0;

    zero_e = '{value: 16'h0000, dpv: 4'b0000, bmask: 4'b1110};
    cur    = zero_e;
    tbl[0] = '{value: 16'h1234, dpv: 4'b0000, bmask: 4'b0000};
    tbl[1] = '{value: 16'hAAAA, dpv: 4'b0000, bmask: 4'b0000};
    tbl[2] = '{value: 16'hBBBB, dpv: 4'b0000, bmask: 4'b0000};
    tbl[3] = '{value: 16'h0050, dpv: 4'b0000, bmask: 4'b1100};
    tbl[4] = '{value: 16'h0005, dpv: 4'b0100, bmask: 4'b1000};
    tbl[5] = '{value: 16'h0000, dpv: 4'b0000, bmask: 4'b1110};
    tbl[6] = '{value: 16'h0000, dpv: 4'b1000, bmask: 4'b0000};
    tbl[7] = '{value: 16'h00F0, dpv: 4'b0001, bmask: 4'b1100};

    // Reset held three cycles with valid asserted.
    repeat (3) @(negedge clk);
    #2;
    rst      = 1'b0;
    in_valid = 1'b0;

    // Each table value: accepted, promoted at the next boundary, shown a frame.
    for (int i = 0; i < 8; i++) begin
      send(tbl[i]);
      wait_ticks(2);
    end

    // Backpressure: second value waits until the first is promoted.
    send(tbl[1]);
    send(tbl[2]);
    wait_ticks(3);

    // Capture on the boundary edge itself waits one more frame.
    wait_ph(15);
    send(tbl[3]);
    wait_ticks(3);

    // Disable mid-dwell of digit 2, then resume.
    send(tbl[0]);
    wait_ticks(2);
    wait_ph(9);
    enable = 1'b0;
    repeat (10) step();
    enable = 1'b1;
    wait_ticks(2);

    // Reset while a value is pending mid-frame.
    wait_ph(4);
    send(tbl[2]);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_ticks(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
